dig_cfg_sequencer: RTL and testbench

//  Owns the ADC serial-control port feeding the DIG_SPI spi_master (16b write, 8b read per transaction).

---
 rtl/dig_cfg_sequencer_pkg.sv | 27 ++
 rtl/dig_cfg_boot_rom.sv | 11 +
 rtl/dig_cfg_sequencer.sv | 149 ++++++++++++++
 tb/tb_dig_cfg_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dig_cfg_sequencer_pkg.sv
// rtl/dig_cfg_sequencer_pkg.sv - state encodings and boot table for dig_cfg_sequencer
package dig_cfg_sequencer_pkg;

  localparam logic [2:0] ST_INIT_WAIT = 3'd0;
  localparam logic [2:0] ST_BOOT_REQ  = 3'd1;
  localparam logic [2:0] ST_BOOT_GAP  = 3'd2;
  localparam logic [2:0] ST_IDLE      = 3'd3;
  localparam logic [2:0] ST_HOST_REQ  = 3'd4;
  localparam logic [2:0] ST_HOST_GAP  = 3'd5;

  typedef struct packed {
    logic        sel;
    logic [15:0] data;
  } spi_word_t;

  // Software reset to each digitizer, then the 0x42 config write to each.
  function automatic spi_word_t boot_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    boot_entry = {1'b0, 16'h0001};
      4'd1:    boot_entry = {1'b1, 16'h0001};
      4'd2:    boot_entry = {1'b0, 16'h4200};
      4'd3:    boot_entry = {1'b1, 16'h4200};
      default: boot_entry = {1'b0, 16'h0000};
    endcase
  endfunction

endpackage

// File: rtl/dig_cfg_boot_rom.sv
// rtl/dig_cfg_boot_rom.sv - combinational boot-table lookup
module dig_cfg_boot_rom
  import dig_cfg_sequencer_pkg::*;
(
  input  logic [3:0] idx,
  output spi_word_t  entry
);

  assign entry = boot_entry(idx);

endmodule

// File: rtl/dig_cfg_sequencer.sv
// rtl/dig_cfg_sequencer.sv - boot-table player and host arbiter for the digitizer SPI port
module dig_cfg_sequencer
  import dig_cfg_sequencer_pkg::*;
#(
  parameter int INIT_DELAY     = 12500,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int N_BOOT         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_sel,
  input  logic [15:0] host_wr_data,
  output logic        host_ack,
  output logic [7:0]  host_rd_data,
  input  logic        boot_start,
  output logic        boot_done,
  output logic        timeout_err,
  output logic        spi_req,
  output logic        spi_sel,
  output logic [15:0] spi_wr_data,
  input  logic        spi_ack,
  input  logic [7:0]  spi_rd_data
);

  localparam logic [15:0] INIT_LAST = 16'(INIT_DELAY - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(N_BOOT - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [3:0]  idx;
  logic [3:0]  rom_idx;
  spi_word_t   rom_word;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // The ROM is addressed with the index of the entry about to be issued.
  assign rom_idx = (state == ST_BOOT_GAP && idx != LAST_IDX) ? idx + 4'd1 : 4'd0;

  dig_cfg_boot_rom u_boot_rom (
    .idx   (rom_idx),
    .entry (rom_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_INIT_WAIT;
      cnt          <= 16'd0;
      idx          <= 4'd0;
      spi_req      <= 1'b0;
      spi_sel      <= 1'b0;
      spi_wr_data  <= 16'd0;
      host_ack     <= 1'b0;
      host_rd_data <= 8'd0;
      boot_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        ST_INIT_WAIT: begin
          if (cnt == INIT_LAST) begin
            state       <= ST_BOOT_REQ;
            idx         <= 4'd0;
            cnt         <= 16'd0;
            spi_req     <= 1'b1;
            spi_sel     <= rom_word.sel;
            spi_wr_data <= rom_word.data;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_BOOT_REQ: begin
          if (spi_ack || cnt == TO_LAST) begin
            if (!spi_ack) timeout_err <= 1'b1;
            spi_req <= 1'b0;
            cnt     <= 16'd0;
            state   <= ST_BOOT_GAP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_BOOT_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= 16'd0;
            if (idx == LAST_IDX) begin
              state     <= ST_IDLE;
              boot_done <= 1'b1;
            end else begin
              idx         <= idx + 4'd1;
              state       <= ST_BOOT_REQ;
              spi_req     <= 1'b1;
              spi_sel     <= rom_word.sel;
              spi_wr_data <= rom_word.data;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_IDLE: begin
          if (host_req) begin
            state       <= ST_HOST_REQ;
            cnt         <= 16'd0;
            spi_req     <= 1'b1;
            spi_sel     <= host_sel;
            spi_wr_data <= host_wr_data;
          end else if (boot_start) begin
            state       <= ST_BOOT_REQ;
            boot_done   <= 1'b0;
            idx         <= 4'd0;
            cnt         <= 16'd0;
            spi_req     <= 1'b1;
            spi_sel     <= rom_word.sel;
            spi_wr_data <= rom_word.data;
          end
        end
        ST_HOST_REQ: begin
          if (spi_ack || cnt == TO_LAST) begin
            host_rd_data <= spi_ack ? spi_rd_data : 8'hFF;
            if (!spi_ack) timeout_err <= 1'b1;
            host_ack <= 1'b1;
            spi_req  <= 1'b0;
            cnt      <= 16'd0;
            state    <= ST_HOST_GAP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_HOST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 16'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state   <= ST_INIT_WAIT;
          cnt     <= 16'd0;
          spi_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dig_cfg_sequencer.sv
// tb/tb_dig_cfg_sequencer.sv - directed self-checking bench for dig_cfg_sequencer
module tb_dig_cfg_sequencer;

  localparam int INIT_DELAY = 12500;
  localparam int GAP        = 16;
  localparam int TIMEOUT    = 4096;
  localparam int RESP_DLY   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_req = 1'b0;
  logic        host_sel = 1'b0;
  logic [15:0] host_wr_data = 16'd0;
  logic        host_ack;
  logic [7:0]  host_rd_data;
  logic        boot_start = 1'b0;
  logic        boot_done;
  logic        timeout_err;
  logic        spi_req;
  logic        spi_sel;
  logic [15:0] spi_wr_data;
  logic        spi_ack = 1'b0;
  logic [7:0]  spi_rd_data = 8'hEE;

  int total = 0;
  int bad   = 0;

  logic [16:0] txq[$];
  logic [16:0] bt[4] = '{17'h00001, 17'h10001, 17'h04200, 17'h14200};
  int   cyc = 0, rise_cyc = 0, fall_cyc = 0, done_rise_cyc = 0, ack_cyc = 0, host_ack_cyc = 0;
  int   low_cnt = 0, min_gap = 1000000, host_ack_cnt = 0, unstable = 0, req_age = 0;
  bit   have_prev = 0, resp_en = 1, prev_req = 0, prev_done = 0;
  logic [16:0] prev_word = '0;
  logic [7:0]  rd_val = 8'h5A;
  int   mark;

  always #5 clk = ~clk;

  dig_cfg_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .host_req     (host_req),
    .host_sel     (host_sel),
    .host_wr_data (host_wr_data),
    .host_ack     (host_ack),
    .host_rd_data (host_rd_data),
    .boot_start   (boot_start),
    .boot_done    (boot_done),
    .timeout_err  (timeout_err),
    .spi_req      (spi_req),
    .spi_sel      (spi_sel),
    .spi_wr_data  (spi_wr_data),
    .spi_ack      (spi_ack),
    .spi_rd_data  (spi_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor plus SPI responder that acks RESP_DLY cycles into each request.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (spi_req && !prev_req) begin
      txq.push_back({spi_sel, spi_wr_data});
      rise_cyc = cyc;
      if (have_prev && low_cnt < min_gap) min_gap = low_cnt;
      have_prev = 1;
    end
    if (spi_req && prev_req && {spi_sel, spi_wr_data} != prev_word) unstable++;
    if (!spi_req && prev_req) fall_cyc = cyc;
    low_cnt = spi_req ? 0 : low_cnt + 1;
    if (boot_done && !prev_done) done_rise_cyc = cyc;
    if (host_ack) begin host_ack_cnt++; host_ack_cyc = cyc; end
    req_age = spi_req ? req_age + 1 : 0;
    if (spi_req && resp_en && req_age == RESP_DLY) begin
      spi_ack = 1'b1; spi_rd_data = rd_val; ack_cyc = cyc;
    end else begin
      spi_ack = 1'b0; spi_rd_data = 8'hEE;
    end
    prev_req = spi_req; prev_word = {spi_sel, spi_wr_data}; prev_done = boot_done;
  end

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!boot_done && n < bound) begin @(negedge clk); n++; end
    if (!boot_done) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_hack(input string tag, input int bound);
    int n = 0;
    @(negedge clk);
    while (!host_ack && n < bound) begin @(negedge clk); n++; end
    if (!host_ack) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_boot(input string tag, input int base);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_e%0d", tag, i), (base + i < txq.size()) ? txq[base + i] : 17'h1FFFF, bt[i]);
  endtask

  task automatic do_reset_release();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    txq.delete(); have_prev = 0; min_gap = 1000000; host_ack_cnt = 0; unstable = 0;
    rst = 1'b1; mark = cyc;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_spi_req", spi_req, 0);
    chk("rst_spi_sel", spi_sel, 0);
    chk("rst_wr_data", spi_wr_data, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_rd_data", host_rd_data, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_timeout", timeout_err, 0);

    // 1: boot sequence
    do_reset_release();
    wait_done("t1_done", INIT_DELAY + 1000);
    chk("t1_first_req", (txq.size() > 0) ? 0 : 1, 0);
    chk("t1_count", txq.size(), 4);
    check_boot("t1", 0);
    chk("t1_min_gap_ok", (min_gap >= GAP) ? 1 : 0, 1);
    chk("t1_done_after_gap", done_rise_cyc - fall_cyc, GAP);
    chk("t1_stable", unstable, 0);
    chk("t1_no_timeout", timeout_err, 0);

    // 2: host read after boot
    repeat (5) @(negedge clk);
    txq.delete(); host_ack_cnt = 0;
    host_sel = 1'b1; host_wr_data = 16'h8100; rd_val = 8'h5A; host_req = 1'b1; mark = cyc;
    wait_hack("t2_ack", 200);
    host_req = 1'b0;
    chk("t2_latency", rise_cyc - mark, 1);
    chk("t2_word", (txq.size() > 0) ? txq[0] : 17'h0, 17'h18100);
    chk("t2_rd_data", host_rd_data, 8'h5A);
    chk("t2_ack_delay", host_ack_cyc - ack_cyc, 1);
    repeat (GAP + 5) @(negedge clk);
    chk("t2_ack_once", host_ack_cnt, 1);
    chk("t2_single_tx", txq.size(), 1);

    // 4: host transaction with no spi_ack
    txq.delete(); host_ack_cnt = 0; resp_en = 0;
    host_sel = 1'b0; host_wr_data = 16'h1234; host_req = 1'b1;
    wait_hack("t4_ack", TIMEOUT + 50);
    host_req = 1'b0;
    chk("t4_req_len", fall_cyc - rise_cyc, TIMEOUT);
    chk("t4_rd_ff", host_rd_data, 8'hFF);
    chk("t4_timeout_err", timeout_err, 1);
    repeat (GAP + 5) @(negedge clk);
    chk("t4_ack_once", host_ack_cnt, 1);
    resp_en = 1;

    // 6: host_req and boot_start together in IDLE
    txq.delete(); host_ack_cnt = 0;
    host_sel = 1'b1; host_wr_data = 16'h0F0F; rd_val = 8'hC3;
    host_req = 1'b1; boot_start = 1'b1;
    @(negedge clk); boot_start = 1'b0;
    wait_hack("t6_ack", 200);
    host_req = 1'b0;
    chk("t6_host_first", (txq.size() > 0) ? txq[0] : 17'h0, 17'h10F0F);
    chk("t6_rd_data", host_rd_data, 8'hC3);
    repeat (100) @(negedge clk);
    chk("t6_boot_dropped", txq.size(), 1);
    chk("t6_done_kept", boot_done, 1);
    boot_start = 1'b1;
    @(negedge clk); boot_start = 1'b0;
    chk("t6_done_cleared", boot_done, 0);
    wait_done("t6_done", 2000);
    chk("t6_count", txq.size(), 5);
    check_boot("t6", 1);
    chk("t6_timeout_sticky", timeout_err, 1);

    // 3: host_req pending from INIT_WAIT
    do_reset_release();
    chk("t3_timeout_cleared", timeout_err, 0);
    repeat (10) @(negedge clk);
    host_sel = 1'b1; host_wr_data = 16'hABCD; rd_val = 8'h33; host_req = 1'b1;
    wait_hack("t3_ack", INIT_DELAY + 1000);
    host_req = 1'b0;
    chk("t3_count", txq.size(), 5);
    check_boot("t3", 0);
    chk("t3_host_word", (txq.size() > 4) ? txq[4] : 17'h0, 17'h1ABCD);
    chk("t3_after_done", rise_cyc - done_rise_cyc, 1);
    chk("t3_rd_data", host_rd_data, 8'h33);
    repeat (100) @(negedge clk);
    chk("t3_ack_once", host_ack_cnt, 1);
    chk("t3_no_repeat", txq.size(), 5);

    // 5: async reset during BOOT_REQ idx=2
    do_reset_release();
    begin
      int n = 0;
      while (txq.size() < 3 && n < INIT_DELAY + 1000) begin @(negedge clk); n++; end
    end
    chk("t5_reached_idx2", txq.size(), 3);
    repeat (5) @(negedge clk);
    chk("t5_req_before", spi_req, 1);
    #2 rst = 1'b0;
    #1 chk("t5_async_drop", spi_req, 0);
    @(negedge clk);
    txq.delete(); have_prev = 0; min_gap = 1000000;
    rst = 1'b1; mark = cyc;
    wait_done("t5_done", INIT_DELAY + 1000);
    chk("t5_count", txq.size(), 4);
    check_boot("t5", 0);
    chk("t5_min_gap_ok", (min_gap >= GAP) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // The first-request timing is measured from the monitor's record of the release.
  int first_rise_seen = 0;
  always @(posedge clk) begin
    #2;
    if (rst && txq.size() == 1 && first_rise_seen == 0 && rise_cyc > mark) begin
      first_rise_seen = 1;
      chk("first_req_cycle", rise_cyc - mark, INIT_DELAY);
    end
    if (!rst) first_rise_seen = 0;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "global timeout");
  end

endmodule
